noise_filter_3x3: RTL
=====================

Name: noise_filter_3x3

Overview:
- Parametrised streaming spatial noise filter for the camera-to-VGA pixel path.
- Generalises the earlier 2-tap RGB888 horizontal averager in four ways: any channel count and width, runtime mode select, and a true 3x3 window from two line buffers.
- Edge replication replaces line-buffer clearing. Rounding replaces truncation.
- No backpressure: pixels arrive at video timing and leave after a fixed latency.

Parameters:
- IMG_W, 320, active pixels per line (line-buffer depth).
- IMG_H, 240, active lines per frame (row counter saturation bound).
- CH, 3, colour channels per pixel.
- CW, 8, bits per channel.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; synchronous, active-high. One clock domain only.
- mode  in  2  filter mode: 0 bypass, 1 H2, 2 H3, 3 G3x3. Sampled only on in_sof.
- in_valid  in  1  in_pixel is valid this cycle.
- in_sof  in  1  first pixel of frame; qualified by in_valid.
- in_eol  in  1  last pixel of line; qualified by in_valid.
- in_pixel  in  CH*CW  channel 0 in the MSBs.
- out_valid  out  1  out_pixel is valid.
- out_sof  out  1  delayed in_sof.
- out_eol  out  1  delayed in_eol.
- out_pixel  out  CH*CW  filtered pixel.
- line_err  out  1  sticky flag: line length mismatch in the current frame.

Behaviour:
- Reset: all outputs 0, x=0, y=0, mode_q=0 (bypass). Line-buffer contents are don't-care; they are never read before being written, because of edge clamping.
- Coordinates: x increments on each valid pixel. in_eol resets x to 0 and increments y, saturating at IMG_H-1. in_sof forces x=0, y=0 and loads mode_q from mode. If in_sof and in_eol arrive together, the pixel is at (0,0) and y becomes 1 afterwards.
- Latency: exactly 2 cycles from an accepted input to its output. out_valid, out_sof and out_eol are in_valid, in_sof and in_eol delayed 2 cycles. No gaps are inserted.
- Window: causal. It covers rows y-2..y and columns x-2..x.
  - Row clamp: at y=0, rows y-1 and y-2 use row y. At y=1, row y-2 uses row y-1.
  - Column clamp: at x=0, columns x-1 and x-2 use column x. At x=1, column x-2 uses column x-1.
  - Output is therefore spatially offset by (+1,+1) in modes 2 and 3; this is accepted.
- Line buffers:
  - LB0 holds row y-1 and LB1 holds row y-2, both addressed by x.
  - Each accepted pixel reads LB0[x] and LB1[x] in cycle 0.
  - In cycle 1, in_pixel is written to LB0[x] and the old LB0[x] to LB1[x].
  - Read-before-write per address.
- Per-channel arithmetic is unsigned and done at full width before shifting:
  - mode 0: out = centre pixel (delayed).
  - mode 1: (p[x-1] + p[x] + 1) >> 1, on row y.
  - mode 2: (p[x-2] + 2p[x-1] + p[x] + 2) >> 2, on row y.
  - mode 3: kernel [1 2 1; 2 4 2; 1 2 1]. Sum width is CW+4; out = (sum + 8) >> 4.
  - The result never exceeds 2^CW-1, so no saturation is needed.
- line_err:
  - Set when x reaches IMG_W-1 without in_eol. Writes at x >= IMG_W are suppressed and x holds at IMG_W-1.
  - Also set when in_eol arrives with x != IMG_W-1.
  - Cleared on in_sof, unless the in_sof pixel itself errs.
- Mode change mid-frame has no effect until the next in_sof.
- Reset mid-frame: the pipeline flushes and nothing valid is output. The next frame starts only at in_sof; pixels before it are filtered with x and y counting from 0.

Decomposition:
- Package noise_filter_pkg: mode constants MODE_BYPASS, MODE_H2, MODE_H3, MODE_G3X3; helper function for sum widths (CW+1, CW+2, CW+4).
- Sub-module filter_line_buffer: one simple dual-port RAM, parameters DEPTH and WIDTH, synchronous read, read-before-write. Instantiated twice.

Test Plan:
- Bypass, CH=3, CW=8, ramp frame 320x240 -> out_pixel equals in_pixel 2 cycles later; out_sof and out_eol aligned; line_err=0.
- mode 1, row 0 pixels R=0x10 then 0x13 -> first output 0x10 (x=0 replicated), second output 0x12 (rounded, (16+19+1)>>1).
- mode 3, constant 0x80 frame -> every output 0x80, including rows 0-1 and columns 0-1.
- mode 3, single 0xFF impulse at (100,50) on zero background:
  - output 0x40 at the position for input (101,51);
  - 0x20 at (100,51), (102,51), (101,50) and (101,52);
  - 0x10 at the four diagonals.
- Line of 319 pixels with in_eol -> line_err=1; it stays 1 through the frame and clears on the next in_sof.
- mode toggled 3->0 mid-frame, then rst asserted for 1 cycle mid-line -> filtering stays mode 3 until rst; out_valid is 0 for 2 cycles after rst; the next in_sof frame is bypass.

Source files
------------

// File: rtl/noise_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noise_filter_pkg
// Brief    : Filter mode encodings and accumulator width helper.
// Revision : 1.0 - initial release
// ============================================================================
package noise_filter_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_H2     = 2'd1;
    localparam logic [1:0] MODE_H3     = 2'd2;
    localparam logic [1:0] MODE_G3X3   = 2'd3;

    // Width of the unshifted per-channel sum for a given mode.
    function automatic int sum_width(input logic [1:0] m, input int cw);
        case (m)
            MODE_H2:   return cw + 1;
            MODE_H3:   return cw + 2;
            MODE_G3X3: return cw + 4;
            default:   return cw;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : filter_line_buffer
// Brief    : Simple dual-port RAM, synchronous read, read-before-write.
// Revision : 1.0 - initial release
// ============================================================================
module filter_line_buffer
    import noise_filter_pkg::*;
#(
    parameter int DEPTH = 320,
    parameter int WIDTH = 24,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/noise_filter_3x3.sv
`default_nettype none
// ============================================================================
// Module   : noise_filter_3x3
// Brief    : Streaming causal 3x3 noise filter (bypass/H2/H3/Gaussian 3x3).
// Revision : 1.0 - initial release
// ============================================================================
module noise_filter_3x3
    import noise_filter_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int CH    = 3,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [CH*CW-1:0] in_pixel,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [CH*CW-1:0] out_pixel,
    output logic             line_err
);

    localparam int c_XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_PW = CH * CW;
    localparam int c_W1 = sum_width(MODE_H2, CW);
    localparam int c_W2 = sum_width(MODE_H3, CW);
    localparam int c_W4 = sum_width(MODE_G3X3, CW);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_H - 1);

    // Stage 0: coordinate tracking and control
    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic [1:0]      r_mode;
    logic            r_ovf;
    logic            r_line_err;

    logic [c_XW-1:0] w_x_eff;
    logic [c_YW-1:0] w_y_eff;
    logic [1:0]      w_mode_eff;
    logic            w_ovf_eff;
    logic            w_at_last;
    logic            w_err_now;

    // Stage 1: window assembly
    logic             r_v1, r_sof1, r_eol1;
    logic [c_PW-1:0]  r_pix1;
    logic [c_XW-1:0]  r_x1;
    logic             r_row0_1, r_row1_1, r_we1;
    logic [1:0]       r_mode1;
    logic [c_PW-1:0]  w_rd0, w_rd1;
    logic [c_PW-1:0]  r_c1 [3];
    logic [c_PW-1:0]  r_c2 [3];
    logic [c_PW-1:0]  w_col0 [3];
    logic [c_PW-1:0]  w_col1 [3];
    logic [c_PW-1:0]  w_col2 [3];
    logic [c_PW-1:0]  w_filt;
    logic             w_x1_zero, w_x1_one;

    // Output stage
    logic             r_out_valid, r_out_sof, r_out_eol;
    logic [c_PW-1:0]  r_out_pixel;

    assign w_x_eff    = in_sof ? '0 : r_x;
    assign w_y_eff    = in_sof ? '0 : r_y;
    assign w_mode_eff = in_sof ? mode : r_mode;
    assign w_ovf_eff  = in_sof ? 1'b0 : r_ovf;
    assign w_at_last  = (w_x_eff == c_X_LAST);
    assign w_err_now  = in_valid & (in_eol ? ~w_at_last : w_at_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= MODE_BYPASS;
            r_ovf       <= 1'b0;
            r_line_err  <= 1'b0;
            r_v1        <= 1'b0;
            r_sof1      <= 1'b0;
            r_eol1      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_pixel <= '0;
        end else begin
            r_v1        <= in_valid;
            r_sof1      <= in_valid & in_sof;
            r_eol1      <= in_valid & in_eol;
            r_out_valid <= r_v1;
            r_out_sof   <= r_sof1;
            r_out_eol   <= r_eol1;
            if (r_v1) begin
                r_out_pixel <= w_filt;
            end
            if (in_valid) begin
                r_mode     <= w_mode_eff;
                r_line_err <= (in_sof ? 1'b0 : r_line_err) | w_err_now;
                if (in_eol) begin
                    r_x   <= '0;
                    r_y   <= (w_y_eff == c_Y_LAST) ? w_y_eff : w_y_eff + c_YW'(1);
                    r_ovf <= 1'b0;
                end else if (w_at_last) begin
                    // Overlong line: hold x and stop writing the line buffers.
                    r_x   <= w_x_eff;
                    r_y   <= w_y_eff;
                    r_ovf <= 1'b1;
                end else begin
                    r_x   <= w_x_eff + c_XW'(1);
                    r_y   <= w_y_eff;
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_pix1   <= in_pixel;
            r_x1     <= w_x_eff;
            r_row0_1 <= (w_y_eff == '0);
            r_row1_1 <= (w_y_eff == c_YW'(1));
            r_mode1  <= w_mode_eff;
            r_we1    <= ~w_ovf_eff;
        end
        if (r_v1) begin
            for (int i = 0; i < 3; i++) begin
                r_c1[i] <= w_col0[i];
                r_c2[i] <= w_col1[i];
            end
        end
    end

    filter_line_buffer #(.DEPTH(IMG_W), .WIDTH(c_PW), .AW(c_XW)) u_lb0 (
        .clk       (clk),
        .i_wr_en   (r_v1 & r_we1),
        .i_wr_addr (r_x1),
        .i_wr_data (r_pix1),
        .i_rd_en   (in_valid),
        .i_rd_addr (w_x_eff),
        .o_rd_data (w_rd0)
    );

    filter_line_buffer #(.DEPTH(IMG_W), .WIDTH(c_PW), .AW(c_XW)) u_lb1 (
        .clk       (clk),
        .i_wr_en   (r_v1 & r_we1),
        .i_wr_addr (r_x1),
        .i_wr_data (w_rd0),
        .i_rd_en   (in_valid),
        .i_rd_addr (w_x_eff),
        .o_rd_data (w_rd1)
    );

    assign w_x1_zero = (r_x1 == '0);
    assign w_x1_one  = (r_x1 == c_XW'(1));

    // Index 0 = row y-2, 1 = row y-1, 2 = row y; edges replicate inward.
    always_comb begin
        w_col0[0] = r_row0_1 ? r_pix1 : (r_row1_1 ? w_rd0 : w_rd1);
        w_col0[1] = r_row0_1 ? r_pix1 : w_rd0;
        w_col0[2] = r_pix1;
        for (int i = 0; i < 3; i++) begin
            w_col1[i] = w_x1_zero ? w_col0[i] : r_c1[i];
            w_col2[i] = w_x1_zero ? w_col0[i] : (w_x1_one ? r_c1[i] : r_c2[i]);
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        localparam int c_LSB = k * CW;
        logic [CW-1:0]   w_b0, w_b1, w_b2;
        logic [c_W1-1:0] w_s1;
        logic [c_W2-1:0] w_s2, w_v0, w_v1, w_v2;
        logic [c_W4-1:0] w_s4;
        logic [CW-1:0]   w_res;

        assign w_b0 = w_col0[2][c_LSB +: CW];
        assign w_b1 = w_col1[2][c_LSB +: CW];
        assign w_b2 = w_col2[2][c_LSB +: CW];
        assign w_s1 = c_W1'(w_b1) + c_W1'(w_b0) + c_W1'(1);
        assign w_s2 = c_W2'(w_b2) + (c_W2'(w_b1) << 1) + c_W2'(w_b0) + c_W2'(2);
        assign w_v0 = c_W2'(w_col0[0][c_LSB +: CW]) + (c_W2'(w_col0[1][c_LSB +: CW]) << 1)
                    + c_W2'(w_col0[2][c_LSB +: CW]);
        assign w_v1 = c_W2'(w_col1[0][c_LSB +: CW]) + (c_W2'(w_col1[1][c_LSB +: CW]) << 1)
                    + c_W2'(w_col1[2][c_LSB +: CW]);
        assign w_v2 = c_W2'(w_col2[0][c_LSB +: CW]) + (c_W2'(w_col2[1][c_LSB +: CW]) << 1)
                    + c_W2'(w_col2[2][c_LSB +: CW]);
        assign w_s4 = c_W4'(w_v2) + (c_W4'(w_v1) << 1) + c_W4'(w_v0) + c_W4'(8);

        always_comb begin
            case (r_mode1)
                MODE_BYPASS: w_res = w_b0;
                MODE_H2:     w_res = CW'(w_s1 >> 1);
                MODE_H3:     w_res = CW'(w_s2 >> 2);
                default:     w_res = CW'(w_s4 >> 4);
            endcase
        end

        assign w_filt[c_LSB +: CW] = w_res;
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_pixel = r_out_pixel;
    assign line_err  = r_line_err;

endmodule
`default_nettype wire
